// File: rtl/seq_mult16_cla_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package seq_mult16_cla_pkg;

    // Operand width handled by the multiplier and its adder.
    localparam int WIDTH = 16;

    // Number of shift-and-add iterations per product (one per multiplier bit).
    localparam int ITER = 16;

    // Controller states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder built from four 4-bit lookahead groups.
module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [15:0] carry;
    logic [3:0]  groupGen;
    logic [3:0]  groupProp;
    logic [4:0]  groupCarry;

    // Bit-level generate/propagate terms.
    always_comb begin
        gen  = a & b;
        prop = a ^ b;
    end

    // Group generate/propagate summaries for each 4-bit slice.
    always_comb begin
        groupGen  = '0;
        groupProp = '0;
        for (int grp = 0; grp < 4; grp++) begin
            groupGen[grp] = gen[4*grp+3]
                          | (prop[4*grp+3] & gen[4*grp+2])
                          | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                          | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp]);
            groupProp[grp] = &prop[4*grp +: 4];
        end
    end

    // Second-level lookahead: carry into every group straight from cin.
    always_comb begin
        groupCarry[0] = cin;
        groupCarry[1] = groupGen[0] | (groupProp[0] & cin);
        groupCarry[2] = groupGen[1] | (groupProp[1] & groupGen[0])
                      | (groupProp[1] & groupProp[0] & cin);
        groupCarry[3] = groupGen[2] | (groupProp[2] & groupGen[1])
                      | (groupProp[2] & groupProp[1] & groupGen[0])
                      | (groupProp[2] & groupProp[1] & groupProp[0] & cin);
        groupCarry[4] = groupGen[3] | (groupProp[3] & groupGen[2])
                      | (groupProp[3] & groupProp[2] & groupGen[1])
                      | (groupProp[3] & groupProp[2] & groupProp[1] & groupGen[0])
                      | (groupProp[3] & groupProp[2] & groupProp[1] & groupProp[0] & cin);
    end

    // First-level lookahead: carries inside each group from that group's carry-in.
    always_comb begin
        carry = '0;
        for (int grp = 0; grp < 4; grp++) begin
            carry[4*grp]   = groupCarry[grp];
            carry[4*grp+1] = gen[4*grp] | (prop[4*grp] & groupCarry[grp]);
            carry[4*grp+2] = gen[4*grp+1] | (prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+1] & prop[4*grp] & groupCarry[grp]);
            carry[4*grp+3] = gen[4*grp+2] | (prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & groupCarry[grp]);
        end
    end

    // Final sum bits and carry out of the top group.
    always_comb begin
        sum  = prop ^ carry;
        cout = groupCarry[4];
    end

endmodule

// File: rtl/seq_mult16_cla.sv
// Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier, one partial
// product per clock through a single cla_adder16, with start/busy/done handshake.
module seq_mult16_cla #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    import seq_mult16_cla_pkg::*;

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [WIDTH-1:0]   accHi_q,   accHi_d;
    logic [WIDTH-1:0]   accLo_q,   accLo_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addIn;
    logic [WIDTH-1:0]   addSum;
    logic               addCout;

    // Partial product: the multiplicand only when the current multiplier bit is set.
    always_comb begin
        addIn = mplier_q[0] ? mcand_q : '0;
    end

    cla_adder16 u_adder (
        .a    (accHi_q),
        .b    (addIn),
        .cin  (1'b0),
        .sum  (addSum),
        .cout (addCout)
    );

    // Next-state and datapath control; the adder carry becomes the new top bit
    // of the accumulator so nothing is lost when the sum is shifted right.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    accHi_d  = '0;
                    accLo_d  = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                accHi_d  = {addCout, addSum[WIDTH-1:1]};
                accLo_d  = {addSum[0], accLo_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ITER - 1)) begin
                    product_d = {addCout, addSum, accLo_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Handshake outputs decoded from the registered state, so they are glitch-free
    // and can never be high together.
    always_comb begin
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
        product = product_q;
    end

endmodule

// File: tb/tb_seq_mult16_cla.sv
// Self-checking bench for seq_mult16_cla: directed cases plus random operands
// checked against plain integer multiplication.
module tb_seq_mult16_cla;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          compareCount;
    int          mismatchCount;
    logic [31:0] lastProduct;

    seq_mult16_cla dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: the product is simply the unsigned integer product.
    function automatic logic [31:0] refProduct(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // Present operands with start for one edge, then scramble a/b since they
    // must be ignored once captured.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        checkOutput("busyAccept", {31'd0, busy}, 32'd1);
        checkOutput("doneAccept", {31'd0, done}, 32'd0);
    endtask

    // Follow the 16 iteration edges after acceptance; optionally pulse start
    // (with a junk multiplicand) before iteration edge pokeCycle.
    task automatic waitResult(input logic [31:0] expProd, input int pokeCycle);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == pokeCycle) begin
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i < 16) begin
                checkOutput("busyRun", {31'd0, busy}, 32'd1);
                checkOutput("doneRun", {31'd0, done}, 32'd0);
                checkOutput("productHold", product, lastProduct);
            end else begin
                checkOutput("doneHigh", {31'd0, done}, 32'd1);
                checkOutput("busyLowAtDone", {31'd0, busy}, 32'd0);
                checkOutput("product", product, expProd);
                lastProduct = expProd;
            end
        end
        start = 1'b0;
    endtask

    // One cycle after DONE with start low: back to idle, done dropped, product held.
    task automatic checkIdle();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("doneDrop", {31'd0, done}, 32'd0);
        checkOutput("busyIdle", {31'd0, busy}, 32'd0);
        checkOutput("productIdle", product, lastProduct);
    endtask

    task automatic runOp(input logic [15:0] x, input logic [15:0] y);
        applyStimulus(x, y);
        waitResult(refProduct(x, y), 0);
        checkIdle();
    endtask

    initial begin
        logic        sawDone;
        logic [15:0] rx;
        logic [15:0] ry;

        compareCount  = 0;
        mismatchCount = 0;
        lastProduct   = 32'd0;
        start         = 1'b0;
        a             = 16'd0;
        b             = 16'd0;
        rst_n         = 1'b0;

        // Reset state.
        #12;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetProduct", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        runOp(16'h0003, 16'h0005);
        runOp(16'hFFFF, 16'hFFFF);
        runOp(16'h1234, 16'h0000);
        runOp(16'h0000, 16'hABCD);
        runOp(16'hABCD, 16'h0001);

        // Start pulsed mid-run must be ignored.
        applyStimulus(16'h0100, 16'h0100);
        waitResult(32'h00010000, 5);
        checkIdle();

        // Reset in the middle of an operation.
        applyStimulus(16'h00FF, 16'h00FF);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        lastProduct = 32'd0;
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetDone", {31'd0, done}, 32'd0);
        checkOutput("midResetProduct", product, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checkOutput("noActivityAfterReset", {31'd0, sawDone}, 32'd0);
        runOp(16'h00FF, 16'h00FF);

        // Back-to-back: start held in the DONE cycle.
        applyStimulus(16'h0002, 16'h0003);
        waitResult(32'h00000006, 0);
        applyStimulus(16'h0007, 16'h0009);
        waitResult(32'h0000003F, 0);
        checkIdle();

        // Random operands, sometimes chained back-to-back.
        for (int n = 0; n < 12; n++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            applyStimulus(rx, ry);
            waitResult(refProduct(rx, ry), (n % 3 == 1) ? int'($urandom_range(1, 15)) : 0);
            if ($urandom_range(0, 1) == 0) checkIdle();
        end
        checkIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
